// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the fixed divide-by-zero quotient.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

    // Multiply countdown only ever needs MUL_LAT-2 <= 6.
    localparam int MUL_CNT_W = 3;

    // Quotient on divide-by-zero is all ones; replicated to WIDTH at the use site.
    localparam logic DIV0_QUO_FILL = 1'b1;

    function automatic logic is_div_op(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter_if.sv
// Request/response bundle between the EX stage (master) and the mul/div unit (slave).
interface muldiv_iter_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic             op_ready;
    md_op_e           op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             busy;

    modport master (
        output op_valid, op, a, b, res_ready,
        input  op_ready, res_valid, res_hi, res_lo, busy
    );

    modport slave (
        input  op_valid, op, a, b, res_ready,
        output op_ready, res_valid, res_hi, res_lo, busy
    );
endinterface

// File: rtl/muldiv_div_core.sv
// Restoring shift-subtract divider on operand magnitudes. One quotient bit per
// cycle; the sign fixup is folded combinationally into the final iteration.
module muldiv_div_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             active;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] pquo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] a_raw;
    logic             neg_q;
    logic             neg_r;
    logic             div0;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic             qbit;
    logic [WIDTH-1:0] prem_nxt;
    logic [WIDTH-1:0] pquo_nxt;

    assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

    // The working remainder is WIDTH+1 bits once the next dividend bit is shifted in.
    assign shifted  = {prem, pquo[WIDTH-1]};
    assign qbit     = (shifted >= {1'b0, dvs});
    assign prem_nxt = qbit ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
    assign pquo_nxt = {pquo[WIDTH-2:0], qbit};

    assign done = active && (cnt == CNT_W'(WIDTH - 1));
    assign quo  = div0 ? {WIDTH{DIV0_QUO_FILL}} : (neg_q ? -pquo_nxt : pquo_nxt);
    assign rem  = div0 ? a_raw : (neg_r ? -prem_nxt : prem_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= '0;
            prem   <= '0;
            pquo   <= '0;
            dvs    <= '0;
            a_raw  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
        end else if (abort) begin
            active <= 1'b0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            prem   <= '0;
            pquo   <= a_mag;
            dvs    <= b_mag;
            a_raw  <= a;
            neg_q  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= is_signed & a[WIDTH-1];
            div0   <= (b == '0);
        end else if (active) begin
            prem <= prem_nxt;
            pquo <= pquo_nxt;
            cnt  <= cnt + 1'b1;
            if (done) active <= 1'b0;
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Handshaked iterative MULT/MULTU/DIV/DIVU unit producing a HI/LO pair that is
// held until the consumer takes it; flush aborts anything in flight.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    muldiv_iter_if.slave bus
);

    localparam logic [MUL_CNT_W-1:0] MUL_CNT_INIT =
        (MUL_LAT > 1) ? MUL_CNT_W'(MUL_LAT - 2) : '0;

    md_state_e state, state_nxt;

    logic                 accept;
    logic                 acc_div;
    logic                 acc_mul;
    logic                 op_ready;
    logic                 res_valid;
    logic                 busy;
    logic [MUL_CNT_W-1:0] mcnt;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic                 mul_sgn;
    logic [2*WIDTH-1:0]   mul_a;
    logic [2*WIDTH-1:0]   mul_b;
    logic [2*WIDTH-1:0]   prod;

    logic                 div_done;
    logic [WIDTH-1:0]     div_quo;
    logic [WIDTH-1:0]     div_rem;

    assign accept  = bus.op_valid & (state == ST_IDLE) & ~flush;
    assign acc_div = accept & is_div_op(bus.op);
    assign acc_mul = accept & ~is_div_op(bus.op);

    // Extending both operands to 2*WIDTH makes the low half of one unsigned
    // multiply correct for both MULT and MULTU.
    assign mul_sgn = (bus.op == MD_MULT);
    assign mul_a   = {{WIDTH{mul_sgn & bus.a[WIDTH-1]}}, bus.a};
    assign mul_b   = {{WIDTH{mul_sgn & bus.b[WIDTH-1]}}, bus.b};
    assign prod    = mul_a * mul_b;

    muldiv_div_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (acc_div),
        .abort     (flush),
        .is_signed (bus.op == MD_DIV),
        .a         (bus.a),
        .b         (bus.b),
        .done      (div_done),
        .quo       (div_quo),
        .rem       (div_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            ST_IDLE: begin
                op_ready = 1'b1;
                busy     = 1'b0;
                if (accept) begin
                    if (is_div_op(bus.op)) state_nxt = ST_DIV;
                    else if (MUL_LAT == 1) state_nxt = ST_DONE;
                    else                   state_nxt = ST_MUL;
                end
            end
            ST_MUL:  if (mcnt == '0) state_nxt = ST_DONE;
            ST_DIV:  if (div_done)   state_nxt = ST_DONE;
            ST_DONE: begin
                res_valid = 1'b1;
                if (bus.res_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (flush) state_nxt = ST_IDLE;
    end

    // The product lands in the result registers at acceptance; the FSM only
    // delays when it is exposed as valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcnt <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (acc_mul) begin
                {hi_q, lo_q} <= prod;
                mcnt         <= MUL_CNT_INIT;
            end else if (state == ST_MUL && mcnt != '0) begin
                mcnt <= mcnt - 1'b1;
            end
            if (state == ST_DIV && div_done && !flush) begin
                hi_q <= div_rem;
                lo_q <= div_quo;
            end
        end
    end

    assign bus.op_ready  = op_ready;
    assign bus.res_valid = res_valid;
    assign bus.busy      = busy;
    assign bus.res_hi    = hi_q;
    assign bus.res_lo    = lo_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: a 32-bit/MUL_LAT=2 instance and a
// 16-bit/MUL_LAT=1 instance, each checked against an arithmetic reference model.
module tb_muldiv_iter;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst32, flush32, rst16, flush16;
    muldiv_iter_if #(.WIDTH(32)) b32();
    muldiv_iter_if #(.WIDTH(16)) b16();

    muldiv_iter #(.WIDTH(32), .MUL_LAT(2)) dut32 (
        .clk(clk), .rst(rst32), .flush(flush32), .bus(b32.slave));
    muldiv_iter #(.WIDTH(16), .MUL_LAT(1)) dut16 (
        .clk(clk), .rst(rst16), .flush(flush16), .bus(b16.slave));

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];
    exp_t e32, e16;
    int   errs = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   mon_on = 0;
    int   rr_mode32 = 0;  // 0 hold low, 1 hold high, 2 random
    logic pv32;
    logic [31:0] ph32, pl32;
    md_op_e      o;
    logic [31:0] x, y;

    always @(posedge clk) cyc++;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endfunction

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic void model(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                                  input int w, output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] msk, ua, ub, up;
        logic signed [63:0] sa, sb;
        msk = (64'd1 << w) - 64'd1;
        ua  = {32'd0, a} & msk;
        ub  = {32'd0, b} & msk;
        sa  = ua[w-1] ? $signed(ua) - $signed(msk) - 64'sd1 : $signed(ua);
        sb  = ub[w-1] ? $signed(ub) - $signed(msk) - 64'sd1 : $signed(ub);
        hi  = '0;
        lo  = '0;
        if (op == MD_MULT || op == MD_MULTU) begin
            up = (op == MD_MULT) ? $unsigned(sa * sb) : ua * ub;
            hi = 32'((up >> w) & msk);
            lo = 32'(up & msk);
        end else if (ub == 64'd0) begin
            hi = 32'(ua);
            lo = 32'(msk);
        end else if (op == MD_DIV) begin
            lo = 32'($unsigned(sa / sb) & msk);
            hi = 32'($unsigned(sa % sb) & msk);
        end else begin
            lo = 32'(ua / ub);
            hi = 32'(ua % ub);
        end
    endfunction

    // Scoreboard for the 32-bit instance.
    always @(negedge clk) if (mon_on) begin
        chk("busy32", 32'(b32.busy), 32'(q32.size() != 0));
        chk("op_ready32", 32'(b32.op_ready), 32'(q32.size() == 0));
        if (q32.size() == 0) chk("valid32", 32'(b32.res_valid), 32'd0);
        else                 chk("valid32", 32'(b32.res_valid), 32'(cyc >= q32[0].due));
        if (b32.res_valid && pv32) begin
            chk("hold_hi32", b32.res_hi, ph32);
            chk("hold_lo32", b32.res_lo, pl32);
        end
        if (rst32 || flush32) q32.delete();
        else begin
            if (b32.res_valid && b32.res_ready && q32.size() != 0) begin
                chk("res_hi32", b32.res_hi, q32[0].hi);
                chk("res_lo32", b32.res_lo, q32[0].lo);
                void'(q32.pop_front());
            end
            if (b32.op_valid && b32.op_ready) begin
                model(b32.op, b32.a, b32.b, 32, e32.hi, e32.lo);
                e32.due = cyc + (is_div_op(b32.op) ? 33 : 2);
                q32.push_back(e32);
            end
        end
        pv32 = b32.res_valid;
        ph32 = b32.res_hi;
        pl32 = b32.res_lo;
    end

    // Scoreboard for the 16-bit instance.
    always @(negedge clk) if (mon_on) begin
        chk("busy16", 32'(b16.busy), 32'(q16.size() != 0));
        if (q16.size() == 0) chk("valid16", 32'(b16.res_valid), 32'd0);
        else                 chk("valid16", 32'(b16.res_valid), 32'(cyc >= q16[0].due));
        if (b16.res_valid && b16.res_ready && q16.size() != 0) begin
            chk("res_hi16", 32'(b16.res_hi), q16[0].hi);
            chk("res_lo16", 32'(b16.res_lo), q16[0].lo);
            void'(q16.pop_front());
        end
        if (b16.op_valid && b16.op_ready && !flush16 && !rst16) begin
            model(b16.op, 32'(b16.a), 32'(b16.b), 16, e16.hi, e16.lo);
            e16.due = cyc + (is_div_op(b16.op) ? 17 : 1);
            q16.push_back(e16);
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        b32.res_ready = (rr_mode32 == 2) ? 1'($urandom) : (rr_mode32 == 1);
    end

    task automatic issue32(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        b32.op_valid = 1'b1;
        b32.op = op;
        b32.a = a;
        b32.b = b;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (b32.op_ready && !flush32 && !rst32) begin
                @(posedge clk);
                #1;
                b32.op_valid = 1'b0;
                b32.op = md_op_e'(2'($urandom_range(0, 3)));
                b32.a = $urandom;
                b32.b = $urandom;
                return;
            end
        end
        checks++;
        errs++;
        $display("FAIL issue32: op_ready got 0 for 400 cycles, expected 1");
        b32.op_valid = 1'b0;
    endtask

    task automatic drain32();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (q32.size() == 0 && !b32.res_valid) return;
        end
        checks++;
        errs++;
        $display("FAIL drain32: %0d results outstanding, expected 0", q32.size());
    endtask

    task automatic wait_valid32();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (b32.res_valid) return;
        end
        checks++;
        errs++;
        $display("FAIL wait_valid32: res_valid got 0 for 100 cycles, expected 1");
    endtask

    task automatic run16(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        b16.op_valid = 1'b1;
        b16.op = op;
        b16.a = a[15:0];
        b16.b = b[15:0];
        @(posedge clk);
        #1;
        b16.op_valid = 1'b0;
        b16.a = 16'($urandom);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #2;
            if (q16.size() == 0 && !b16.res_valid) return;
        end
        checks++;
        errs++;
        $display("FAIL run16: %0d results outstanding, expected 0", q16.size());
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached with %0d errors", errs);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst32 = 1'b1; flush32 = 1'b0; rst16 = 1'b1; flush16 = 1'b0;
        b32.op_valid = 1'b0; b32.op = MD_MULT; b32.a = '0; b32.b = '0;
        b16.op_valid = 1'b0; b16.op = MD_MULT; b16.a = '0; b16.b = '0; b16.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst32 = 1'b0;
        rst16 = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        chk("reset_valid", 32'(b32.res_valid), 32'd0);
        chk("reset_hi", b32.res_hi, 32'd0);
        chk("reset_lo", b32.res_lo, 32'd0);
        chk("reset_ready", 32'(b32.op_ready), 32'd1);

        // Directed cases, consumer always ready.
        rr_mode32 = 1;
        issue32(MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003);
        issue32(MD_MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
        issue32(MD_DIV,   32'hFFFF_FFF9, 32'd2);
        issue32(MD_DIVU,  32'd100,       32'd7);
        issue32(MD_DIVU,  32'h0000_1234, 32'd0);
        issue32(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        issue32(MD_DIV,   32'h0000_0011, 32'd0);
        drain32();

        // Back-pressure: result held 5+ cycles, next request waits in DONE.
        rr_mode32 = 0;
        issue32(MD_MULTU, $urandom, $urandom);
        wait_valid32();
        repeat (5) @(negedge clk);
        b32.op_valid = 1'b1;
        b32.op = MD_MULT;
        repeat (2) @(negedge clk);
        rr_mode32 = 1;
        issue32(MD_MULT, $urandom, $urandom);
        drain32();

        // Flush in DIV at cycle 10 while a new request is also presented.
        issue32(MD_DIV, $urandom, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        flush32 = 1'b1;
        b32.op_valid = 1'b1;
        b32.op = MD_DIVU;
        @(posedge clk);
        #1;
        flush32 = 1'b0;
        b32.op_valid = 1'b0;
        repeat (40) @(posedge clk);
        // Flush in IDLE must also win over acceptance.
        #1;
        flush32 = 1'b1;
        b32.op_valid = 1'b1;
        @(posedge clk);
        #1;
        flush32 = 1'b0;
        b32.op_valid = 1'b0;
        issue32(MD_DIVU, 32'd9, 32'd3);
        drain32();

        // Random back-to-back traffic with a random consumer.
        rr_mode32 = 2;
        for (int i = 0; i < 30; i++) begin
            o = md_op_e'(2'($urandom_range(0, 3)));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = '0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: begin x = $urandom_range(0, 1000); y = $urandom_range(1, 50); end
                default: ;
            endcase
            issue32(o, x, y);
        end
        rr_mode32 = 1;
        drain32();

        // Reset while holding a result.
        rr_mode32 = 0;
        issue32(MD_MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_valid32();
        @(posedge clk);
        #1;
        rst32 = 1'b1;
        @(posedge clk);
        #1;
        rst32 = 1'b0;
        @(negedge clk);
        chk("rst_done_valid", 32'(b32.res_valid), 32'd0);
        chk("rst_done_hi", b32.res_hi, 32'd0);
        chk("rst_done_lo", b32.res_lo, 32'd0);
        chk("rst_done_ready", 32'(b32.op_ready), 32'd1);
        rr_mode32 = 1;
        issue32(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        drain32();

        // 16-bit, single-cycle multiply instance.
        run16(MD_MULTU, 32'hFFFE, 32'h0003);
        run16(MD_MULT,  32'hFFFE, 32'h0003);
        run16(MD_DIV,   32'h8000, 32'hFFFF);
        run16(MD_DIVU,  32'h0123, 32'h0000);
        run16(MD_DIV,   32'hFFF9, 32'h0002);
        for (int i = 0; i < 12; i++)
            run16(md_op_e'(2'($urandom_range(0, 3))), $urandom, 32'($urandom_range(0, 3) == 0 ? 0 : $urandom));

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
